// File: rtl/uimac_tx_arbiter.sv
// Round-robin arbiter sharing the MAC transmit path between the ARP and IP/UDP layers.
// A grant is held from the one-cycle ack until the MAC busy handshake completes or a timeout fires.
module uimac_tx_arbiter #(
  parameter logic [1:0]  IP_TYPE       = 2'b01,
  parameter logic [1:0]  ARP_TYPE      = 2'b10,
  parameter logic [15:0] GRANT_TIMEOUT = 16'd1024
) (
  input  logic        I_mac_tclk,
  input  logic        I_reset,
  input  logic        I_arp_req,
  output logic        O_arp_ack,
  input  logic        I_arp_tvalid,
  input  logic [7:0]  I_arp_tdata,
  input  logic [47:0] I_arp_tdest_addr,
  input  logic        I_ip_req,
  output logic        O_ip_ack,
  input  logic        I_ip_tvalid,
  input  logic [7:0]  I_ip_tdata,
  input  logic [47:0] I_ip_tdest_addr,
  input  logic        I_mac_tbusy,
  output logic        O_mac_tvalid,
  output logic [7:0]  O_mac_tdata,
  output logic [1:0]  O_mac_tdata_type,
  output logic [47:0] O_mac_tdest_addr,
  output logic        O_grant_timeout
);

  localparam logic [15:0] TMO_LAST = GRANT_TIMEOUT - 16'd1;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_START = 2'd1,
    S_XFER       = 2'd2,
    S_WAIT_DONE  = 2'd3
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        win_arp_q;
  logic        last_arp_q;
  logic        busy_seen_q;
  logic [15:0] timer_q;

  logic        grant;
  logic        pick_arp;
  logic        win_tvalid;
  logic [7:0]  win_tdata;
  logic        start_to;
  logic        done_to;

  logic        arp_ack_d;
  logic        ip_ack_d;
  logic        mac_tvalid_d;
  logic [7:0]  mac_tdata_d;
  logic        timeout_d;

  // Tie goes to whichever side did not win last; a sole requester always wins.
  assign pick_arp   = I_arp_req & (~I_ip_req | ~last_arp_q);
  assign grant      = (state_q == S_IDLE) & ~I_mac_tbusy & (I_arp_req | I_ip_req);
  assign win_tvalid = win_arp_q ? I_arp_tvalid : I_ip_tvalid;
  assign win_tdata  = win_arp_q ? I_arp_tdata  : I_ip_tdata;
  assign start_to   = (state_q == S_WAIT_START) & ~win_tvalid & (timer_q == TMO_LAST);
  assign done_to    = (state_q == S_WAIT_DONE) & ~busy_seen_q & ~I_mac_tbusy
                      & (timer_q == TMO_LAST);

  always_ff @(posedge I_mac_tclk or posedge I_reset) begin
    if (I_reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (grant) state_d = S_WAIT_START;
      end
      S_WAIT_START: begin
        if (win_tvalid)    state_d = S_XFER;
        else if (start_to) state_d = S_IDLE;
      end
      S_XFER: begin
        if (!win_tvalid) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (busy_seen_q && !I_mac_tbusy) state_d = S_IDLE;
        else if (done_to)                state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    arp_ack_d    = grant & pick_arp;
    ip_ack_d     = grant & ~pick_arp;
    mac_tvalid_d = 1'b0;
    mac_tdata_d  = 8'd0;
    timeout_d    = start_to | done_to;
    if ((state_q == S_WAIT_START || state_q == S_XFER) && win_tvalid) begin
      mac_tvalid_d = 1'b1;
      mac_tdata_d  = win_tdata;
    end
  end

  // last_arp_q resets to the IP side so ARP takes the first tie after reset.
  always_ff @(posedge I_mac_tclk or posedge I_reset) begin
    if (I_reset) begin
      O_arp_ack        <= 1'b0;
      O_ip_ack         <= 1'b0;
      O_mac_tvalid     <= 1'b0;
      O_mac_tdata      <= 8'd0;
      O_mac_tdata_type <= 2'd0;
      O_mac_tdest_addr <= 48'd0;
      O_grant_timeout  <= 1'b0;
      win_arp_q        <= 1'b0;
      last_arp_q       <= 1'b0;
      busy_seen_q      <= 1'b0;
      timer_q          <= 16'd0;
    end else begin
      O_arp_ack       <= arp_ack_d;
      O_ip_ack        <= ip_ack_d;
      O_mac_tvalid    <= mac_tvalid_d;
      O_mac_tdata     <= mac_tdata_d;
      O_grant_timeout <= timeout_d;

      if (grant) begin
        O_mac_tdata_type <= pick_arp ? ARP_TYPE : IP_TYPE;
        O_mac_tdest_addr <= pick_arp ? I_arp_tdest_addr : I_ip_tdest_addr;
        win_arp_q        <= pick_arp;
        last_arp_q       <= pick_arp;
        busy_seen_q      <= 1'b0;
        timer_q          <= 16'd0;
      end else begin
        if (state_q != S_IDLE && I_mac_tbusy) busy_seen_q <= 1'b1;
        case (state_q)
          S_WAIT_START: timer_q <= timer_q + 16'd1;
          S_XFER: begin
            if (!win_tvalid) timer_q <= 16'd0;
          end
          // Once busy has been seen the timer is irrelevant, so stop it rather than let it wrap.
          S_WAIT_DONE: begin
            if (!busy_seen_q) timer_q <= timer_q + 16'd1;
          end
          default: timer_q <= timer_q;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uimac_tx_arbiter.sv
// Randomized bench for uimac_tx_arbiter: transaction-level round-robin model with
// per-cycle expected stream, timeout and MAC busy behaviour derived from the frame schedule.
module tb_uimac_tx_arbiter;

  localparam int         G     = 8;
  localparam logic [1:0] T_IP  = 2'b01;
  localparam logic [1:0] T_ARP = 2'b10;

  logic        I_mac_tclk = 1'b0;
  logic        I_reset;
  logic        I_arp_req;
  logic        I_arp_tvalid;
  logic [7:0]  I_arp_tdata;
  logic [47:0] I_arp_tdest_addr;
  logic        I_ip_req;
  logic        I_ip_tvalid;
  logic [7:0]  I_ip_tdata;
  logic [47:0] I_ip_tdest_addr;
  logic        I_mac_tbusy;
  logic        O_arp_ack;
  logic        O_ip_ack;
  logic        O_mac_tvalid;
  logic [7:0]  O_mac_tdata;
  logic [1:0]  O_mac_tdata_type;
  logic [47:0] O_mac_tdest_addr;
  logic        O_grant_timeout;

  int n_checks = 0;
  int n_pass   = 0;
  bit mdl_last_arp;

  always #5 I_mac_tclk = ~I_mac_tclk;

  uimac_tx_arbiter #(
    .IP_TYPE      (T_IP),
    .ARP_TYPE     (T_ARP),
    .GRANT_TIMEOUT(16'd8)
  ) dut (
    .I_mac_tclk      (I_mac_tclk),
    .I_reset         (I_reset),
    .I_arp_req       (I_arp_req),
    .O_arp_ack       (O_arp_ack),
    .I_arp_tvalid    (I_arp_tvalid),
    .I_arp_tdata     (I_arp_tdata),
    .I_arp_tdest_addr(I_arp_tdest_addr),
    .I_ip_req        (I_ip_req),
    .O_ip_ack        (O_ip_ack),
    .I_ip_tvalid     (I_ip_tvalid),
    .I_ip_tdata      (I_ip_tdata),
    .I_ip_tdest_addr (I_ip_tdest_addr),
    .I_mac_tbusy     (I_mac_tbusy),
    .O_mac_tvalid    (O_mac_tvalid),
    .O_mac_tdata     (O_mac_tdata),
    .O_mac_tdata_type(O_mac_tdata_type),
    .O_mac_tdest_addr(O_mac_tdest_addr),
    .O_grant_timeout (O_grant_timeout)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic drive_quiet();
    I_arp_req    = 1'b0;
    I_arp_tvalid = 1'b0;
    I_arp_tdata  = 8'h00;
    I_ip_req     = 1'b0;
    I_ip_tvalid  = 1'b0;
    I_ip_tdata   = 8'h00;
    I_mac_tbusy  = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_arp_ack"}, O_arp_ack, 0);
    check({tag, "_ip_ack"}, O_ip_ack, 0);
    check({tag, "_tvalid"}, O_mac_tvalid, 0);
    check({tag, "_tdata"}, O_mac_tdata, 0);
    check({tag, "_type"}, O_mac_tdata_type, 0);
    check({tag, "_dest"}, O_mac_tdest_addr, 0);
    check({tag, "_timeout"}, O_grant_timeout, 0);
  endtask

  // mode 0: normal frame with MAC busy pulse; 1: winner never starts; 2: MAC busy never rises.
  // who 0: ARP only, 1: IP only, 2: both request.
  // Time index k counts falling edges from the ack cycle (k = 0).
  task automatic run_grant(input int mode, input int who);
    bit          ra, ri, exp_arp, ev, wv;
    logic [47:0] da, di;
    logic [7:0]  frame [0:15];
    logic [7:0]  exp_d;
    int          pb, len, t0, br, bf, bon, boff, kend, to_k;

    ra = (who != 1);
    ri = (who != 0);
    if (ra && ri) exp_arp = !mdl_last_arp;
    else          exp_arp = ra;
    da   = {16'($urandom), $urandom};
    di   = {16'($urandom), $urandom};
    pb   = $urandom_range(0, 3);
    len  = $urandom_range(1, 16);
    t0   = $urandom_range(0, 3);
    br   = $urandom_range(0, 2);
    bf   = $urandom_range(1, 3);
    bon  = t0 + 1 + br;
    boff = (t0 + len + bf > bon + 1) ? t0 + len + bf : bon + 1;
    for (int i = 0; i < 16; i++) frame[i] = 8'($urandom);
    case (mode)
      1:       begin kend = G + 1;           to_k = G;               end
      2:       begin kend = t0 + len + G + 2; to_k = t0 + len + G + 1; end
      default: begin kend = boff + 1;        to_k = -1;              end
    endcase

    I_arp_req        = ra;
    I_ip_req         = ri;
    I_arp_tdest_addr = da;
    I_ip_tdest_addr  = di;
    I_mac_tbusy      = (pb > 0);
    for (int k = 1; k <= pb; k++) begin
      @(negedge I_mac_tclk);
      check("ack_while_busy", {O_arp_ack, O_ip_ack}, 2'b00);
      if (k == pb) I_mac_tbusy = 1'b0;
    end
    @(negedge I_mac_tclk);
    check("arp_ack", O_arp_ack, exp_arp);
    check("ip_ack", O_ip_ack, !exp_arp);
    check("type", O_mac_tdata_type, exp_arp ? T_ARP : T_IP);
    check("dest", O_mac_tdest_addr, exp_arp ? da : di);
    mdl_last_arp = exp_arp;
    I_arp_req = 1'b0;
    I_ip_req  = 1'b0;

    for (int k = 0; k <= kend; k++) begin
      if (k > 0) begin
        @(negedge I_mac_tclk);
        ev    = (mode != 1) && (k >= t0 + 1) && (k <= t0 + len);
        exp_d = 8'h00;
        if (ev) exp_d = frame[k - t0 - 1];
        check("mac_tvalid", O_mac_tvalid, ev);
        check("mac_tdata", O_mac_tdata, exp_d);
        check("grant_timeout", O_grant_timeout, k == to_k);
        if (k == 1) check("ack_one_cycle", {O_arp_ack, O_ip_ack}, 2'b00);
      end
      wv    = (mode != 1) && (k >= t0) && (k < t0 + len);
      exp_d = 8'($urandom);
      if (wv) exp_d = frame[k - t0];
      if (exp_arp) begin
        I_arp_tvalid = wv;
        I_arp_tdata  = exp_d;
        I_ip_tvalid  = 1'($urandom);
        I_ip_tdata   = 8'($urandom);
      end else begin
        I_ip_tvalid  = wv;
        I_ip_tdata   = exp_d;
        I_arp_tvalid = 1'($urandom);
        I_arp_tdata  = 8'($urandom);
      end
      I_mac_tbusy = (mode == 0) && (k >= bon) && (k < boff);
    end
    check("type_held", O_mac_tdata_type, exp_arp ? T_ARP : T_IP);
    check("dest_held", O_mac_tdest_addr, exp_arp ? da : di);
    drive_quiet();
  endtask

  initial begin
    int mode;
    int who;
    I_reset          = 1'b1;
    I_arp_tdest_addr = 48'h0;
    I_ip_tdest_addr  = 48'h0;
    drive_quiet();
    mdl_last_arp = 1'b0;
    repeat (3) @(negedge I_mac_tclk);
    check_all_zero("reset");
    I_reset = 1'b0;
    @(negedge I_mac_tclk);
    check_all_zero("idle");

    for (int it = 0; it < 40; it++) begin
      who  = (it == 0) ? 2 : int'($urandom_range(0, 2));
      mode = int'($urandom_range(0, 7));
      mode = (mode == 0) ? 1 : (mode == 1) ? 2 : 0;
      if (it == 3) mode = 1;
      if (it == 4) mode = 2;
      run_grant(mode, who);
    end

    // Reset in the middle of an IP frame, then a tie must go to ARP.
    I_ip_req        = 1'b1;
    I_ip_tdest_addr = {16'($urandom), $urandom};
    @(negedge I_mac_tclk);
    check("mid_ip_ack", O_ip_ack, 1);
    I_ip_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      I_ip_tvalid = 1'b1;
      I_ip_tdata  = 8'(i + 1);
      @(negedge I_mac_tclk);
    end
    check("mid_tvalid", O_mac_tvalid, 1);
    check("mid_tdata", O_mac_tdata, 8'd20);
    #2 I_reset = 1'b1;
    #1 check_all_zero("async_reset");
    I_ip_tvalid = 1'b0;
    @(negedge I_mac_tclk);
    I_reset          = 1'b0;
    I_arp_req        = 1'b1;
    I_ip_req         = 1'b1;
    I_arp_tdest_addr = 48'h0A0B0C0D0E0F;
    @(negedge I_mac_tclk);
    check("post_reset_arp_ack", O_arp_ack, 1);
    check("post_reset_ip_ack", O_ip_ack, 0);
    check("post_reset_type", O_mac_tdata_type, T_ARP);
    check("post_reset_dest", O_mac_tdest_addr, 48'h0A0B0C0D0E0F);
    drive_quiet();
    @(negedge I_mac_tclk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
